// File: rtl/mac_pkg.sv
// Shared definitions for the receive MAC frame path: descriptor layout,
// Ethernet constants and the frame-reader state encoding.
package mac_pkg;

  localparam int PTR_CRC_ERR = 15;
  localparam int PTR_LEN_ERR = 14;
  localparam int PTR_LEN_MSB = 10;

  localparam logic [15:0] ETH_TYPE_PTP = 16'h88F7;
  localparam int          ETH_HDR_LEN  = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR_POP = 3'd1,
    ST_PTR_LAT = 3'd2,
    ST_XFER    = 3'd3,
    ST_DROP    = 3'd4,
    ST_FLUSH   = 3'd5
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry valid/ready buffer with combinational pass-through when empty.
// Upstream has no ready; the writer throttles itself using occupancy.
module rx_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty     = (cnt == 2'd0);
  // An incoming word bypasses storage only when nothing is queued ahead of it
  // and the consumer takes it right away.
  assign push      = in_valid & ~(empty & out_ready);
  assign pop       = ~empty & out_ready;
  assign out_valid = ~empty | in_valid;
  assign out_data  = !empty ? mem[rd_ptr] : (in_valid ? in_data : '0);
  assign occupancy = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mac_rx_frame_reader.sv
// Per-port receive frame reader: pops a descriptor, then forwards the frame
// bytes onto a handshaked byte bus with header sideband, or drains bad frames.
module mac_rx_frame_reader
  import mac_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int MIN_LEN = 14
) (
  input  logic         clk_sys,
  input  logic         rstn_sys,
  input  logic         ptr_fifo_empty,
  output logic         ptr_fifo_rd,
  input  logic [15:0]  ptr_fifo_dout,
  output logic         data_fifo_rd,
  input  logic [7:0]   data_fifo_dout,
  output logic [7:0]   o_data,
  output logic         o_valid,
  output logic         o_sop,
  output logic         o_eop,
  input  logic         o_ready,
  output logic         hdr_valid,
  output logic [47:0]  hdr_da,
  output logic [47:0]  hdr_sa,
  output logic [15:0]  hdr_type,
  output logic [10:0]  hdr_len,
  output logic         hdr_ptp,
  output logic [15:0]  frame_cnt,
  output logic [15:0]  drop_cnt,
  output logic [2:0]   dbg_state
);

  // Output bus: a byte transfers on a rising clk_sys edge with o_valid and
  // o_ready both high; once o_valid is up, o_data/o_sop/o_eop hold until then.

  rx_state_e        state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pop_cnt;
  logic [LEN_W-1:0] pop_cnt_inc;
  logic [LEN_W-1:0] desc_len;
  logic             desc_bad;
  logic             last_pop;
  logic             room;
  logic             drop_inc;
  logic             frame_inc;
  logic             rd_xfer;
  logic             rd_q;
  logic             rd_sop_q;
  logic             rd_eop_q;
  logic [LEN_W-1:0] rd_idx_q;
  logic [1:0]       skid_occ;
  logic [9:0]       skid_out;
  logic             unused_desc_bits;

  assign unused_desc_bits = ^ptr_fifo_dout[13:11];

  assign desc_len    = LEN_W'(ptr_fifo_dout[PTR_LEN_MSB:0]);
  assign desc_bad    = ptr_fifo_dout[PTR_CRC_ERR] | ptr_fifo_dout[PTR_LEN_ERR] |
                       (desc_len < LEN_W'(MIN_LEN));
  assign pop_cnt_inc = pop_cnt + LEN_W'(1);
  assign last_pop    = (pop_cnt_inc == len_q);
  // Count bytes already in flight from the FIFO so the buffer never overfills.
  assign room        = ((skid_occ + {1'b0, rd_q}) < 2'd2);
  assign rd_xfer     = data_fifo_rd & (state == ST_XFER);
  assign dbg_state   = state;

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ptr_fifo_rd  = 1'b0;
    data_fifo_rd = 1'b0;
    drop_inc     = 1'b0;
    frame_inc    = 1'b0;
    case (state)
      ST_IDLE:    if (!ptr_fifo_empty) state_nxt = ST_PTR_POP;
      ST_PTR_POP: begin
        ptr_fifo_rd = 1'b1;
        state_nxt   = ST_PTR_LAT;
      end
      ST_PTR_LAT: begin
        if (!desc_bad)                   state_nxt = ST_XFER;
        else if (desc_len != '0)         state_nxt = ST_DROP;
        else begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        data_fifo_rd = 1'b1;
        if (last_pop) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (room) begin
          data_fifo_rd = 1'b1;
          if (last_pop) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (o_valid && o_ready && o_eop) begin
          frame_inc = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      len_q     <= '0;
      pop_cnt   <= '0;
      rd_q      <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
      rd_idx_q  <= '0;
      hdr_valid <= 1'b0;
      hdr_da    <= '0;
      hdr_sa    <= '0;
      hdr_type  <= '0;
      hdr_len   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == ST_PTR_LAT) begin
        len_q   <= desc_len;
        pop_cnt <= '0;
      end else if (data_fifo_rd) begin
        pop_cnt <= pop_cnt_inc;
      end

      // Byte tags travel alongside the one-cycle FIFO read latency.
      rd_q <= rd_xfer;
      if (rd_xfer) begin
        rd_sop_q <= (pop_cnt == '0);
        rd_eop_q <= last_pop;
        rd_idx_q <= pop_cnt;
      end

      if (rd_q) begin
        if (rd_idx_q == '0) hdr_len <= 11'(len_q);
        if (rd_idx_q < LEN_W'(6))                hdr_da   <= {hdr_da[39:0], data_fifo_dout};
        else if (rd_idx_q < LEN_W'(12))          hdr_sa   <= {hdr_sa[39:0], data_fifo_dout};
        else if (rd_idx_q < LEN_W'(ETH_HDR_LEN)) hdr_type <= {hdr_type[7:0], data_fifo_dout};
      end
      hdr_valid <= rd_q && (rd_idx_q == LEN_W'(ETH_HDR_LEN - 1));

      if (drop_inc)  drop_cnt  <= sat_inc16(drop_cnt);
      if (frame_inc) frame_cnt <= sat_inc16(frame_cnt);
    end
  end

  assign hdr_ptp = (hdr_type == ETH_TYPE_PTP);

  rx_skid_buf #(.W(10)) u_skid (
    .clk       (clk_sys),
    .rst_n     (rstn_sys),
    .in_valid  (rd_q),
    .in_data   ({data_fifo_dout, rd_sop_q, rd_eop_q}),
    .out_valid (o_valid),
    .out_data  (skid_out),
    .out_ready (o_ready),
    .occupancy (skid_occ)
  );

  assign {o_data, o_sop, o_eop} = skid_out;

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
// Bench for mac_rx_frame_reader: models both MAC FIFOs, pushes expected
// bytes/headers into queues and checks them from a separate output monitor.
module tb_mac_rx_frame_reader;

  localparam logic [47:0] DA = 48'hF0F1F2F3F4F5;
  localparam logic [47:0] SA = 48'hE0E1E2E3E4E5;

  // ---------------- clock / reset / DUT ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rstn_sys;
  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic [7:0]  o_data;
  logic        o_valid, o_sop, o_eop, o_ready;
  logic        hdr_valid;
  logic [47:0] hdr_da, hdr_sa;
  logic [15:0] hdr_type;
  logic [10:0] hdr_len;
  logic        hdr_ptp;
  logic [15:0] frame_cnt, drop_cnt;
  logic [2:0]  dbg_state;

  mac_rx_frame_reader dut (
    .clk_sys        (clk_sys),
    .rstn_sys       (rstn_sys),
    .ptr_fifo_empty (ptr_fifo_empty),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_sop          (o_sop),
    .o_eop          (o_eop),
    .o_ready        (o_ready),
    .hdr_valid      (hdr_valid),
    .hdr_da         (hdr_da),
    .hdr_sa         (hdr_sa),
    .hdr_type       (hdr_type),
    .hdr_len        (hdr_len),
    .hdr_ptp        (hdr_ptp),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0]   exp_q[$];
  logic [123:0] hdr_exp_q[$];
  logic [15:0]  ptr_q[$];
  logic [7:0]   data_q[$];
  int  exp_frames = 0;
  int  exp_drops  = 0;
  int  data_pops  = 0;
  bit  rand_ready = 0;
  logic ptr_rd_s  = 1'b0;
  logic data_rd_s = 1'b0;
  logic stall_prev = 1'b0;
  logic [9:0] stall_word = '0;

  // ---------------- MAC FIFO models (one-cycle read latency) ----------------
  always @(posedge clk_sys) begin
    #1;
    if (rstn_sys) begin
      if (ptr_rd_s && ptr_q.size() > 0)   ptr_fifo_dout  = ptr_q.pop_front();
      if (data_rd_s && data_q.size() > 0) data_fifo_dout = data_q.pop_front();
      ptr_fifo_empty = (ptr_q.size() == 0);
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk_sys) begin
    logic [9:0]   got_w, exp_w;
    logic [123:0] got_h, exp_h;
    ptr_rd_s  = ptr_fifo_rd;
    data_rd_s = data_fifo_rd;
    if (!rstn_sys) begin
      stall_prev = 1'b0;
    end else begin
      got_w = {o_data, o_sop, o_eop};
      if (data_fifo_rd) data_pops++;
      if (stall_prev) begin
        checks++;
        if (!o_valid || got_w != stall_word) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b word=%h, required valid=1 word=%h",
                   o_valid, got_w, stall_word);
        end
      end
      stall_prev = o_valid && !o_ready;
      stall_word = got_w;
      if (o_valid && o_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got {data,sop,eop}=%h, required no byte", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w != exp_w) begin
            errors++;
            $display("FAIL out_byte: got {data,sop,eop}=%h, required %h", got_w, exp_w);
          end
        end
      end
      if (hdr_valid) begin
        checks++;
        got_h = {hdr_da, hdr_sa, hdr_type, hdr_len, hdr_ptp};
        if (hdr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_hdr: got %h, required no header", got_h);
        end else begin
          exp_h = hdr_exp_q.pop_front();
          if (got_h != exp_h) begin
            errors++;
            $display("FAIL hdr: got %h, required %h", got_h, exp_h);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [15:0] etype);
    if (i < 6)        return 8'hF0 + 8'(i);
    else if (i < 12)  return 8'hE0 + 8'(i - 6);
    else if (i == 12) return etype[15:8];
    else if (i == 13) return etype[7:0];
    else              return 8'(i * 7 + 3);
  endfunction

  task automatic load_frame(input bit crc, input bit lerr, input int len,
                            input logic [15:0] etype, input bit fwd, input bit ptp);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = frame_byte(i, etype);
      data_q.push_back(b);
      if (fwd) exp_q.push_back({b, 1'(i == 0), 1'(i == len - 1)});
    end
    if (fwd) begin
      hdr_exp_q.push_back({DA, SA, etype, 11'(len), ptp});
      exp_frames++;
    end else begin
      exp_drops++;
    end
    ptr_q.push_back({crc, lerr, 3'b000, 11'(len)});
    ptr_fifo_empty = 1'b0;
  endtask

  task automatic send_frame(input string name, input bit crc, input bit lerr, input int len,
                            input logic [15:0] etype, input bit fwd, input bit ptp);
    int start_pops;
    bit done;
    start_pops = data_pops;
    load_frame(crc, lerr, len, etype, fwd, ptp);
    done = 0;
    for (int c = 0; c < 4 * len + 100 && !done; c++) begin
      @(negedge clk_sys);
      #1;
      done = (dbg_state == 3'd0) && ptr_q.size() == 0 && data_q.size() == 0 &&
             exp_q.size() == 0 && hdr_exp_q.size() == 0;
    end
    check({name, "_done"},      128'(done), 128'(1));
    check({name, "_pops"},      128'(data_pops - start_pops), 128'(len));
    check({name, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_frames));
    check({name, "_drop_cnt"},  128'(drop_cnt), 128'(exp_drops));
    if (fwd) check({name, "_hdr_hold"}, 128'({hdr_type, hdr_ptp}), 128'({etype, ptp}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rstn_sys       = 1'b0;
    o_ready        = 1'b1;
    ptr_fifo_empty = 1'b1;
    ptr_fifo_dout  = '0;
    data_fifo_dout = '0;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs",
          128'({o_valid, o_sop, o_eop, o_data, ptr_fifo_rd, data_fifo_rd, hdr_valid, hdr_ptp,
                hdr_type, hdr_len, frame_cnt, drop_cnt}), 128'(0));
    check("reset_hdr_addr", 128'({hdr_da, hdr_sa}), 128'(0));
    check("reset_state", 128'(dbg_state), 128'(0));
    rstn_sys = 1'b1;
    repeat (2) @(negedge clk_sys);

    send_frame("good100_ptp",    0, 0, 100,  16'h88F7, 1, 1);
    send_frame("crc100",         1, 0, 100,  16'h88F7, 0, 0);
    send_frame("good64_aligned", 0, 0, 64,   16'h0800, 1, 0);
    send_frame("lenerr1515",     0, 1, 1515, 16'h0800, 0, 0);
    send_frame("good59_ipv4",    0, 0, 59,   16'h0800, 1, 0);
    rand_ready = 1;
    send_frame("good1515_bp",    0, 0, 1515, 16'h86DD, 1, 0);
    rand_ready = 0;
    send_frame("short10",        0, 0, 10,   16'h0800, 0, 0);
    send_frame("len0",           0, 0, 0,    16'h0800, 0, 0);
    send_frame("min14_ptp",      0, 0, 14,   16'h88F7, 1, 1);
    send_frame("short13",        0, 0, 13,   16'h0800, 0, 0);
    rand_ready = 1;
    send_frame("min14_bp",       0, 0, 14,   16'h88F7, 1, 1);
    send_frame("crc_lenerr15",   1, 1, 15,   16'h0800, 0, 0);
    send_frame("good20_bp",      0, 0, 20,   16'h0806, 1, 0);
    rand_ready = 0;

    // Reset in the middle of a long forwarded frame.
    load_frame(0, 0, 200, 16'h88F7, 1, 1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_sys);
      seen = (dbg_state == 3'd3);
    end
    repeat (30) @(negedge clk_sys);
    check("pre_reset_xfer", 128'(dbg_state), 128'(3));
    #3;
    rstn_sys = 1'b0;
    #1;
    check("midreset_outputs",
          128'({o_valid, o_sop, o_eop, o_data, ptr_fifo_rd, data_fifo_rd, hdr_valid, hdr_ptp,
                hdr_type, hdr_len, frame_cnt, drop_cnt}), 128'(0));
    check("midreset_hdr_addr", 128'({hdr_da, hdr_sa}), 128'(0));
    check("midreset_state", 128'(dbg_state), 128'(0));
    exp_q.delete();
    hdr_exp_q.delete();
    ptr_q.delete();
    data_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    ptr_fifo_empty = 1'b1;
    repeat (2) @(negedge clk_sys);
    rstn_sys = 1'b1;
    repeat (2) @(negedge clk_sys);
    send_frame("post_reset64",   0, 0, 64,   16'h88F7, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_rx_frame_reader.md
# mac_rx_frame_reader

Per-port receive frame reader between the receive MAC (`mac_r_rgmii`) and the switch core, in the `clk_sys` domain. It pops one frame descriptor from the MAC pointer FIFO and then either streams the frame bytes from the MAC data FIFO onto a handshaked byte bus or silently drains them if the frame is bad. It captures DA, SA and EtherType as sideband, flags PTP frames (0x88F7) and keeps good and drop frame counters.

## Interface
Parameters:
- `LEN_W`, 11: byte-length field width in the descriptor.
- `MIN_LEN`, 14: shortest frame that is forwarded. Shorter frames are dropped.

Ports:
- `clk_sys`  in  1: system clock.
- `rstn_sys`  in  1: reset, asynchronous, active-low.
- `ptr_fifo_empty`  in  1: descriptor FIFO empty.
- `ptr_fifo_rd`  out  1: descriptor pop. Data is valid the cycle after the pop.
- `ptr_fifo_dout`  in  16: descriptor. [15] = CRC error, [14] = length error, [13:11] are ignored, [10:0] = byte count stored in the data FIFO (FCS excluded).
- `data_fifo_rd`  out  1: data pop. `data_fifo_dout` is valid the cycle after the pop.
- `data_fifo_dout`  in  8: frame byte.
- `o_data`  out  8: output byte.
- `o_valid`  out  1: output byte valid.
- `o_sop`  out  1: first byte of the frame.
- `o_eop`  out  1: last byte of the frame.
- `o_ready`  in  1: consumer accepts the byte.
- `hdr_valid`  out  1: one-cycle pulse; the header sideband is valid.
- `hdr_da`  out  48: destination address.
- `hdr_sa`  out  48: source address.
- `hdr_type`  out  16: EtherType.
- `hdr_len`  out  11: frame byte count.
- `hdr_ptp`  out  1: set when `hdr_type` == 16'h88F7.
- `frame_cnt`  out  16: count of forwarded frames, saturating.
- `drop_cnt`  out  16: count of dropped frames, saturating.

## Operation
- FSM states are IDLE, PTR_POP, PTR_LAT, XFER, DROP and FLUSH.
- IDLE → PTR_POP when `!ptr_fifo_empty`. In PTR_POP, `ptr_fifo_rd` is asserted for exactly one cycle.
- PTR_LAT registers the descriptor.
  - A frame is bad if [15] is set, [14] is set, or the length is below `MIN_LEN`.
  - Bad frame with length 0: increment `drop_cnt` and go to IDLE.
  - Bad frame with length ≥ 1: go to DROP.
  - Otherwise go to XFER.
- DROP: assert `data_fifo_rd` every cycle for exactly `len` pops. Nothing appears on `o_*`. Increment `drop_cnt` at the last pop, then go to IDLE.
- XFER:
  - Issue `data_fifo_rd` only when the skid buffer has room, counting up to `len` pops.
  - Returned bytes enter the skid buffer, which drives `o_*`.
  - `o_sop` is set on byte 0 and `o_eop` on byte `len-1`.
  - Bytes 0–5 load `hdr_da` and bytes 6–11 load `hdr_sa`, most significant byte first. Bytes 12–13 load `hdr_type`.
  - `hdr_valid` pulses the cycle after byte 13 returns from the FIFO.
- FLUSH: entered after the last pop in XFER. Wait until the EOP byte is accepted (`o_valid & o_ready & o_eop`), then increment `frame_cnt` and go to IDLE.
- Counters saturate at 16'hFFFF.
- The pop counter is `LEN_W` bits wide and compares for equality against `len`, so it never wraps.
- Reset values: all outputs 0, FSM in IDLE, skid buffer empty.
- Reset is honoured mid-frame. Any partially read frame remains in the MAC FIFOs; the MAC side resets together with this block through `rstn_sys`.

## Timing
- Descriptor overhead is 2 cycles (PTR_POP, PTR_LAT) before the first `data_fifo_rd`.
- Latency from the first `data_fifo_rd` to the first `o_valid` is 1 cycle (FIFO read latency, skid buffer in pass-through).
- With `o_ready` held at 1, XFER moves 1 byte per cycle. A frame of length L occupies L+3 cycles from the IDLE exit until the cycle after the EOP handshake.
- DROP takes `len` cycles plus the 2-cycle overhead.
- Handshake rules:
  - `o_data` and the flags stay stable while `o_valid & !o_ready`.
  - `o_valid` never depends combinationally on `o_ready`.
- Back-pressure: the skid buffer is 2 entries deep. `data_fifo_rd` is suppressed when occupancy + in-flight reads ≥ 2. No byte is lost at any `o_ready` pattern.
- `hdr_valid` may coincide with an output handshake. The header registers hold their value until the next frame's byte 0.
- There are no back-to-back descriptor pops inside a frame. The next PTR_POP can occur in the cycle after a frame returns to IDLE.

## Structure
- Shared package `mac_pkg` holds:
  - descriptor bit positions (`PTR_CRC_ERR` = 15, `PTR_LEN_ERR` = 14, `PTR_LEN_MSB` = 10);
  - `ETH_TYPE_PTP` = 16'h88F7;
  - `ETH_HDR_LEN` = 14;
  - the FSM state encoding.
- One sub-module, `rx_skid_buf`: 2-entry, 10-bit-wide (data, sop, eop) valid/ready buffer with occupancy output.

## Test plan
- Good 100-byte frame, DA f0f1f2f3f4f5, SA e0e1e2e3e4e5, type 0x88F7, `o_ready`=1 → 100 bytes out, matching FIFO content, sop/eop on bytes 0 and 99; `hdr_ptp`=1; `frame_cnt`=1.
- CRC-error descriptor, len 100 → exactly 100 data pops, no `o_valid`, `drop_cnt`=1; a following good frame is aligned correctly.
- Length-error 1515-byte frame, then a 59-byte good frame of type 0x0800 → first frame dropped, second forwarded with `hdr_ptp`=0, `hdr_type`=0x0800.
- Good 1515-byte frame with `o_ready` toggling randomly (50%) → byte-exact output, no loss or duplication, data stable while stalled.
- Descriptor len 10 with flags clear → dropped (below `MIN_LEN`), 10 pops. Descriptor len 0 → no pops, `drop_cnt` incremented.
- `rstn_sys` asserted mid-XFER → all outputs 0 immediately, FSM in IDLE; after release, a fresh frame is forwarded correctly.
